we_rd_seq: RTL

Weight-memory read sequencer. Generates the read-enable/address stream for one weight bank of the NPU. The stream covers K kernels of W words each, and each kernel is replayed R times. A pipelined valid/marker stream is aligned to the 1-cycle BRAM read latency. The block sits between the layer controller (start/config) and the weight memory read port (C_rd_en/C_rd_addr or C1_rd_en/C1_rd_addr), with the PE array applying back-pressure.

---
 rtl/we_rd_seq_pkg.sv | 19 +
 rtl/we_rd_cnt.sv | 92 +++++++++
 rtl/we_rd_seq.sv | 100 ++++++++++
 3 files changed

// File: rtl/we_rd_seq_pkg.sv
// Shared NPU definitions for the weight-memory read sequencer:
// FSM encoding, default widths and the counter wrap-flag bundle.
package we_rd_seq_pkg;

  localparam int DEF_ADDR_WIDTH = 14;
  localparam int DEF_CNT_WIDTH  = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic w_last;
    logic r_last;
    logic k_last;
  } cnt_flags_t;

endpackage

// File: rtl/we_rd_cnt.sv
// Nested word/pass/kernel counter that produces the weight read address,
// replaying each kernel from its start address until its passes are used up.
module we_rd_cnt
  import we_rd_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  words_per_kernel,
  input  logic [CNT_WIDTH-1:0]  kernel_cnt,
  input  logic [CNT_WIDTH-1:0]  reuse_cnt,
  output logic [ADDR_WIDTH-1:0] addr,
  output cnt_flags_t            flags
);

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] addr_q, addr_d, kstart_q, kstart_d;
  logic [CNT_WIDTH-1:0]  w_q, w_d, r_q, r_d, k_q, k_d;
  logic [CNT_WIDTH-1:0]  w_max_q, w_max_d, r_max_q, r_max_d, k_max_q, k_max_d;

  assign flags.w_last = (w_q == w_max_q);
  assign flags.r_last = (r_q == r_max_q);
  assign flags.k_last = (k_q == k_max_q);
  assign addr         = addr_q;

  // Limits are stored as count-1 so the wrap flags are plain equality compares.
  always_comb begin
    addr_d   = addr_q;
    kstart_d = kstart_q;
    w_d      = w_q;
    r_d      = r_q;
    k_d      = k_q;
    w_max_d  = w_max_q;
    r_max_d  = r_max_q;
    k_max_d  = k_max_q;
    if (load) begin
      addr_d   = base_addr;
      kstart_d = base_addr;
      w_d      = '0;
      r_d      = '0;
      k_d      = '0;
      w_max_d  = words_per_kernel - CNT_ONE;
      r_max_d  = reuse_cnt - CNT_ONE;
      k_max_d  = kernel_cnt - CNT_ONE;
    end else if (advance) begin
      if (!flags.w_last) begin
        w_d    = w_q + CNT_ONE;
        addr_d = addr_q + ADDR_ONE;
      end else if (!flags.r_last) begin
        w_d    = '0;
        r_d    = r_q + CNT_ONE;
        addr_d = kstart_q;
      end else if (!flags.k_last) begin
        w_d      = '0;
        r_d      = '0;
        k_d      = k_q + CNT_ONE;
        addr_d   = addr_q + ADDR_ONE;
        kstart_d = addr_q + ADDR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      kstart_q <= '0;
      w_q      <= '0;
      r_q      <= '0;
      k_q      <= '0;
      w_max_q  <= '0;
      r_max_q  <= '0;
      k_max_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      kstart_q <= kstart_d;
      w_q      <= w_d;
      r_q      <= r_d;
      k_q      <= k_d;
      w_max_q  <= w_max_d;
      r_max_q  <= r_max_d;
      k_max_q  <= k_max_d;
    end
  end

endmodule

// File: rtl/we_rd_seq.sv
// Weight-memory read sequencer: FSM plus a 1-cycle valid/marker pipeline
// aligned to the BRAM read latency, driving one weight bank read port.
module we_rd_seq
  import we_rd_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  words_per_kernel,
  input  logic [CNT_WIDTH-1:0]  kernel_cnt,
  input  logic [CNT_WIDTH-1:0]  reuse_cnt,
  input  logic                  stall,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic                  rd_pass_last,
  output logic                  rd_kernel_last,
  output logic                  busy,
  output logic                  done
);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  pass_last_q, pass_last_d;
  logic                  kernel_last_q, kernel_last_d;
  logic                  accept, cfg_zero, load, issue, all_last;
  logic [ADDR_WIDTH-1:0] cnt_addr;
  cnt_flags_t            flags;

  assign accept   = (state_q == ST_IDLE) && start;
  assign cfg_zero = (words_per_kernel == '0) || (kernel_cnt == '0) || (reuse_cnt == '0);
  assign load     = accept && !cfg_zero;
  assign issue    = (state_q == ST_ISSUE) && !stall;
  assign all_last = flags.w_last && flags.r_last && flags.k_last;

  we_rd_cnt #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk             (clk),
    .rst             (rst),
    .load            (load),
    .advance         (issue),
    .base_addr       (base_addr),
    .words_per_kernel(words_per_kernel),
    .kernel_cnt      (kernel_cnt),
    .reuse_cnt       (reuse_cnt),
    .addr            (cnt_addr),
    .flags           (flags)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = cfg_zero ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (issue && all_last) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The read port address only moves on an issued read; between reads it holds.
  always_comb begin
    last_addr_d   = issue ? cnt_addr : last_addr_q;
    rd_valid_d    = issue;
    pass_last_d   = issue && flags.w_last;
    kernel_last_d = issue && flags.w_last && flags.r_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_addr_q   <= '0;
      rd_valid_q    <= 1'b0;
      pass_last_q   <= 1'b0;
      kernel_last_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_addr_q   <= last_addr_d;
      rd_valid_q    <= rd_valid_d;
      pass_last_q   <= pass_last_d;
      kernel_last_q <= kernel_last_d;
    end
  end

  assign rd_en          = issue;
  assign rd_addr        = issue ? cnt_addr : last_addr_q;
  assign rd_valid       = rd_valid_q;
  assign rd_pass_last   = pass_last_q;
  assign rd_kernel_last = kernel_last_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);

endmodule
